cache_set: RTL and testbench

- N-way set-associative cache set: per-way word storage plus tag/valid/dirty metadata, parallel tag compare, true-LRU victim selection.
- Sits between the L1 controller FSM and the per-index set array. One instance per cache index.
- Generalises a single cache line to WAYS lines with hit detection, registered lookup pipeline, replacement policy and bulk invalidate.

---
 rtl/cache_pkg.sv | 12 +
 rtl/cache_set_lru_age.sv | 38 +++
 rtl/cache_set.sv | 146 ++++++++++++++
 tb/tb_cache_set.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared width helpers for the cache set and its LRU tracker
package cache_pkg;

  function automatic int offset_width(input int cache_line_width);
    return cache_line_width - 2;
  endfunction

  function automatic int way_width(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/cache_set_lru_age.sv
// rtl/cache_set_lru_age.sv - true-LRU age counters (0 = MRU) with touch and bulk reset
module lru_age import cache_pkg::*; #(
  parameter  int WAYS      = 4,
  localparam int WAY_WIDTH = way_width(WAYS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inv,
  input  logic                 touch_en,
  input  logic [WAY_WIDTH-1:0] touch_way,
  output logic [WAY_WIDTH-1:0] lru_way
);

  logic [WAY_WIDTH-1:0] age [WAYS];
  logic [WAY_WIDTH-1:0] touch_age;

  assign touch_age = age[touch_way];

  // Ages stay a permutation: only ways younger than the touched one shift down by one.
  always_ff @(posedge clk) begin
    if (!rst_n || inv) begin
      for (int i = 0; i < WAYS; i++) age[i] <= WAY_WIDTH'(i);
    end else if (touch_en) begin
      for (int i = 0; i < WAYS; i++) begin
        if (WAY_WIDTH'(i) == touch_way) age[i] <= '0;
        else if (age[i] < touch_age)    age[i] <= age[i] + WAY_WIDTH'(1);
      end
    end
  end

  always_comb begin
    lru_way = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (age[i] == WAY_WIDTH'(WAYS - 1)) lru_way = WAY_WIDTH'(i);
    end
  end

endmodule

// File: rtl/cache_set.sv
// rtl/cache_set.sv - N-way set: word storage, tag/valid/dirty metadata, 1-cycle lookup, LRU victim
module cache_set import cache_pkg::*; #(
  parameter  int WAYS             = 4,
  parameter  int TAG_WIDTH        = 20,
  parameter  int CACHE_LINE_WIDTH = 6,
  localparam int OFFSET_WIDTH     = offset_width(CACHE_LINE_WIDTH),
  localparam int WAY_WIDTH        = way_width(WAYS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    lookup_en,
  input  logic [TAG_WIDTH-1:0]    lookup_tag,
  input  logic [OFFSET_WIDTH-1:0] lookup_offset,
  output logic                    r_valid,
  output logic                    r_hit,
  output logic [WAY_WIDTH-1:0]    r_hit_way,
  output logic [31:0]             r_data,
  output logic [WAY_WIDTH-1:0]    victim_way,
  output logic                    victim_valid,
  output logic                    victim_dirty,
  output logic [TAG_WIDTH-1:0]    victim_tag,
  input  logic                    w_en,
  input  logic [WAY_WIDTH-1:0]    w_way,
  input  logic [TAG_WIDTH-1:0]    w_tag,
  input  logic [OFFSET_WIDTH-1:0] w_offset,
  input  logic [31:0]             w_data,
  input  logic [3:0]              w_strb,
  input  logic                    w_dirty,
  input  logic                    w_valid,
  input  logic                    inv_all
);

  localparam int DEPTH = 1 << OFFSET_WIDTH;

  typedef struct packed {
    logic [TAG_WIDTH-1:0] tag;
    logic                 valid;
    logic                 dirty;
  } cache_meta_t;

  cache_meta_t          meta [WAYS];
  logic [31:0]          rd_word [WAYS];
  logic [WAYS-1:0]      match_vec;
  logic                 hit_any;
  logic [WAY_WIDTH-1:0] hit_idx;
  logic                 free_any;
  logic [WAY_WIDTH-1:0] free_idx;
  logic [WAY_WIDTH-1:0] lru_way;
  logic [WAY_WIDTH-1:0] vic_idx;
  logic                 touch_en;
  logic [WAY_WIDTH-1:0] touch_way;

  // Descending scan so the lowest matching / lowest invalid way wins.
  always_comb begin
    match_vec = '0;
    hit_any   = 1'b0;
    hit_idx   = '0;
    free_any  = 1'b0;
    free_idx  = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      match_vec[i] = meta[i].valid && (meta[i].tag == lookup_tag);
      if (match_vec[i]) begin
        hit_any = 1'b1;
        hit_idx = WAY_WIDTH'(i);
      end
      if (!meta[i].valid) begin
        free_any = 1'b1;
        free_idx = WAY_WIDTH'(i);
      end
    end
  end

  assign vic_idx = free_any ? free_idx : lru_way;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_hit        <= 1'b0;
      r_hit_way    <= '0;
      victim_way   <= '0;
      victim_valid <= 1'b0;
      victim_dirty <= 1'b0;
      victim_tag   <= '0;
    end else begin
      r_valid <= lookup_en;
      if (lookup_en) begin
        r_hit        <= hit_any;
        r_hit_way    <= hit_idx;
        victim_way   <= vic_idx;
        victim_valid <= meta[vic_idx].valid;
        victim_dirty <= meta[vic_idx].valid && meta[vic_idx].dirty;
        victim_tag   <= meta[vic_idx].tag;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < WAYS; i++) meta[i] <= '0;
    end else if (inv_all) begin
      for (int i = 0; i < WAYS; i++) begin
        meta[i].valid <= 1'b0;
        meta[i].dirty <= 1'b0;
      end
    end else if (w_en) begin
      meta[w_way].tag   <= w_tag;
      meta[w_way].valid <= w_valid;
      meta[w_way].dirty <= w_dirty;
    end
  end

  // A fill takes precedence over the hit touch from the previous lookup.
  assign touch_en  = (w_en && w_valid) || (r_valid && r_hit);
  assign touch_way = (w_en && w_valid) ? w_way : r_hit_way;

  lru_age #(.WAYS(WAYS)) u_lru (
    .clk       (clk),
    .rst_n     (rst_n),
    .inv       (inv_all),
    .touch_en  (touch_en),
    .touch_way (touch_way),
    .lru_way   (lru_way)
  );

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    logic [31:0] mem [DEPTH];
    logic [31:0] q;

    always_ff @(posedge clk) begin
      if (lookup_en) q <= mem[lookup_offset];
      if (w_en && (w_way == WAY_WIDTH'(g))) begin
        for (int b = 0; b < 4; b++) begin
          if (w_strb[b]) mem[w_offset][8*b +: 8] <= w_data[8*b +: 8];
        end
      end
    end

    assign rd_word[g] = q;
  end

  assign r_data = rd_word[r_hit ? r_hit_way : victim_way];

  // Duplicate valid tags in one set mean the controller filled the same line twice.
  assert property (@(posedge clk) disable iff (!rst_n) lookup_en |-> $onehot0(match_vec));

endmodule

// File: tb/tb_cache_set.sv
// tb/tb_cache_set.sv - randomized scoreboard bench for cache_set against a queue-based LRU model
module tb_cache_set;

  localparam int WAYS = 4;
  localparam int TW   = 20;
  localparam int OW   = 4;
  localparam int WW   = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          lookup_en = 1'b0;
  logic [TW-1:0] lookup_tag = '0;
  logic [OW-1:0] lookup_offset = '0;
  logic          r_valid, r_hit, victim_valid, victim_dirty;
  logic [WW-1:0] r_hit_way, victim_way;
  logic [31:0]   r_data;
  logic [TW-1:0] victim_tag;
  logic          w_en = 1'b0;
  logic [WW-1:0] w_way = '0;
  logic [TW-1:0] w_tag = '0;
  logic [OW-1:0] w_offset = '0;
  logic [31:0]   w_data = '0;
  logic [3:0]    w_strb = '0;
  logic          w_dirty = 1'b0, w_valid = 1'b0, inv_all = 1'b0;

  cache_set #(.WAYS(WAYS), .TAG_WIDTH(TW), .CACHE_LINE_WIDTH(6)) dut (
    .clk(clk), .rst_n(rst_n), .lookup_en(lookup_en), .lookup_tag(lookup_tag),
    .lookup_offset(lookup_offset), .r_valid(r_valid), .r_hit(r_hit), .r_hit_way(r_hit_way),
    .r_data(r_data), .victim_way(victim_way), .victim_valid(victim_valid),
    .victim_dirty(victim_dirty), .victim_tag(victim_tag), .w_en(w_en), .w_way(w_way),
    .w_tag(w_tag), .w_offset(w_offset), .w_data(w_data), .w_strb(w_strb),
    .w_dirty(w_dirty), .w_valid(w_valid), .inv_all(inv_all)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    bit          hit;
    int          hway;
    logic [31:0] data;
    int          vway;
    bit          vvalid;
    bit          vdirty;
    logic [TW-1:0] vtag;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   mon_on = 1'b0;

  // Reference model: line state per way, LRU as an ordered list (front = most recent).
  bit          m_valid [WAYS];
  bit          m_dirty [WAYS];
  logic [TW-1:0] m_tag [WAYS];
  logic [31:0] m_mem [WAYS][16];
  int          order[$];
  bit          pend_hit;
  int          pend_way;

  function void check(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function void touch(int w);
    for (int i = 0; i < order.size(); i++) begin
      if (order[i] == w) begin
        order.delete(i);
        break;
      end
    end
    order.push_front(w);
  endfunction

  function void model_reset();
    for (int i = 0; i < WAYS; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_tag[i]   = '0;
    end
    order = {0, 1, 2, 3};
    pend_hit = 1'b0;
    pend_way = 0;
  endfunction

  task automatic step(input bit le, input logic [TW-1:0] lt, input int lo,
                      input bit we, input int ww, input logic [TW-1:0] wt, input int wo,
                      input logic [31:0] wd, input logic [3:0] ws, input bit wdy,
                      input bit wv, input bit inv, input bit rst);
    exp_t e;
    int h = -1;
    int v = -1;
    @(posedge clk);
    #1;
    rst_n = !rst;  lookup_en = le;  lookup_tag = lt;  lookup_offset = lo[OW-1:0];
    w_en = we;  w_way = ww[WW-1:0];  w_tag = wt;  w_offset = wo[OW-1:0];
    w_data = wd;  w_strb = ws;  w_dirty = wdy;  w_valid = wv;  inv_all = inv;
    if (rst) begin
      model_reset();
      return;
    end
    if (le) begin
      for (int i = 0; i < WAYS; i++) if (h < 0 && m_valid[i] && m_tag[i] == lt) h = i;
      for (int i = 0; i < WAYS; i++) if (v < 0 && !m_valid[i]) v = i;
      if (v < 0) v = order[order.size()-1];
      e.due    = cyc + 1;
      e.hit    = (h >= 0);
      e.hway   = (h >= 0) ? h : 0;
      e.vway   = v;
      e.data   = (h >= 0) ? m_mem[h][lo] : m_mem[v][lo];
      e.vvalid = m_valid[v];
      e.vdirty = m_valid[v] && m_dirty[v];
      e.vtag   = m_tag[v];
      sb.push_back(e);
    end
    if (we) for (int b = 0; b < 4; b++) if (ws[b]) m_mem[ww][wo][8*b +: 8] = wd[8*b +: 8];
    if (inv) begin
      for (int i = 0; i < WAYS; i++) begin
        m_valid[i] = 1'b0;
        m_dirty[i] = 1'b0;
      end
    end else if (we) begin
      m_valid[ww] = wv;
      m_dirty[ww] = wdy;
      m_tag[ww]   = wt;
    end
    if (inv)           order = {0, 1, 2, 3};
    else if (we && wv) touch(ww);
    else if (pend_hit) touch(pend_way);
    pend_hit = le && (h >= 0);
    pend_way = h;
  endtask

  task automatic idle();
    step(0, '0, 0, 0, 0, '0, 0, '0, 4'h0, 0, 0, 0, 0);
  endtask

  task automatic lookup(input logic [TW-1:0] t, input int o);
    step(1, t, o, 0, 0, '0, 0, '0, 4'h0, 0, 0, 0, 0);
  endtask

  task automatic write(input int w, input logic [TW-1:0] t, input int o, input logic [31:0] d,
                       input logic [3:0] s, input bit dy, input bit vl);
    step(0, '0, 0, 1, w, t, o, d, s, dy, vl, 0, 0);
  endtask

  task automatic fill_all(input logic [TW-1:0] base);
    for (int w = 0; w < WAYS; w++) write(w, base + TW'(w), 0, $urandom, 4'hF, 0, 1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_on) begin
      if (r_valid) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL spurious_r_valid: got 1, expected 0 (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          check("latency",      cyc,          e.due);
          check("r_hit",        r_hit,        e.hit);
          check("r_hit_way",    r_hit_way,    e.hway);
          check("r_data",       r_data,       e.data);
          check("victim_way",   victim_way,   e.vway);
          check("victim_valid", victim_valid, e.vvalid);
          check("victim_dirty", victim_dirty, e.vdirty);
          check("victim_tag",   victim_tag,   e.vtag);
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        n_vec++;
        n_err++;
        $display("FAIL missing_r_valid: got 0, expected 1 (cycle %0d)", cyc);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    bit le, we, wv, inv, rst;
    int ww;
    logic [TW-1:0] wt;

    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_r_valid",      r_valid,      0);
    check("reset_r_hit",        r_hit,        0);
    check("reset_r_hit_way",    r_hit_way,    0);
    check("reset_victim_way",   victim_way,   0);
    check("reset_victim_valid", victim_valid, 0);
    check("reset_victim_dirty", victim_dirty, 0);
    check("reset_victim_tag",   victim_tag,   0);
    mon_on = 1'b1;

    for (int w = 0; w < WAYS; w++)
      for (int o = 0; o < 16; o++) write(w, '0, o, $urandom, 4'hF, 0, 0);
    step(0, '0, 0, 0, 0, '0, 0, '0, 4'h0, 0, 0, 0, 1);

    lookup(20'h00001, 0);
    write(2, 20'h12345, 3, 32'hDEADBEEF, 4'hF, 0, 1);
    lookup(20'h12345, 3);
    write(2, 20'h12345, 3, 32'h0000CAFE, 4'h3, 1, 1);
    lookup(20'h12345, 3);
    write(0, 20'h00A00, 1, 32'h0, 4'h0, 0, 1);
    write(1, 20'h00A01, 1, 32'h0, 4'h0, 0, 1);
    write(3, 20'h00A03, 1, 32'h0, 4'h0, 0, 1);
    lookup(20'h99999, 3);

    fill_all(20'h00100);
    lookup(20'h00101, 2);
    lookup(20'h00102, 2);
    lookup(20'h00103, 2);
    idle();
    lookup(20'h77777, 2);
    lookup(20'h00100, 2);
    idle();
    lookup(20'h77777, 2);

    write(1, 20'h00101, 5, 32'h11111111, 4'hF, 0, 1);
    step(1, 20'h00101, 5, 1, 1, 20'h00101, 5, 32'h22222222, 4'hF, 0, 1, 0, 0);
    lookup(20'h00101, 5);

    fill_all(20'h00200);
    step(1, 20'h00203, 0, 1, 3, 20'h00203, 0, 32'h5A5A5A5A, 4'hF, 1, 1, 1, 0);
    lookup(20'h00203, 0);
    lookup(20'h00201, 0);

    fill_all(20'h00300);
    step(1, 20'h00301, 0, 0, 0, '0, 0, '0, 4'h0, 0, 0, 0, 1);
    idle();
    lookup(20'h00301, 0);

    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      inv = ($urandom_range(0, 39) == 0);
      le  = ($urandom_range(0, 9) < 6);
      we  = !rst && ($urandom_range(0, 1) == 1);
      wv  = ($urandom_range(0, 3) != 0);
      ww  = $urandom_range(0, WAYS - 1);
      wt  = TW'($urandom_range(1, 6));
      for (int j = 0; j < WAYS; j++) if (j != ww && m_valid[j] && m_tag[j] == wt) ww = j;
      step(le, TW'($urandom_range(0, 7)), $urandom_range(0, 15), we, ww, wt,
           $urandom_range(0, 15), $urandom, 4'($urandom_range(0, 15)),
           $urandom_range(0, 1) == 1, wv, inv, rst);
    end

    repeat (3) idle();
    @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
